// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with write bypass and busy scoreboard.
// Latency: not applicable (constants only).
// Backpressure: not applicable.
//
// Holds the default geometry and the encoding of the ZERO_REG parameter.
package regfile_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_NUM_READ = 2;

    // ZERO_REG encoding: ON hardwires register 0 to zero and never busy.
    localparam int ZERO_REG_OFF = 0;
    localparam int ZERO_REG_ON  = 1;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: address mux plus zero-register, write bypass and busy-clear bypass.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the port is always ready.
//
// Ports:
//   addr        register address for this port
//   regs, busy  stored register contents and busy vector from the top
//   reset       active reset suppresses the bypass so stored values are returned
//   write_*     this cycle's writeback, forwarded when it targets addr
//   read_data   data for addr
//   read_busy   busy status for addr, with a same-cycle writeback clear applied
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = ZERO_REG_ON,
    parameter int ADDR_W   = $clog2(DEPTH)
)(
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]   regs,
    input  logic [DEPTH-1:0]              busy,
    input  logic                          reset,
    input  logic                          write_en,
    input  logic [ADDR_W-1:0]             write_addr,
    input  logic [WIDTH-1:0]              write_data,
    output logic [WIDTH-1:0]              read_data,
    output logic                          read_busy
);

    localparam bit HAS_ZERO = (ZERO_REG != ZERO_REG_OFF);

    logic is_zero;
    logic hit;

    assign is_zero = HAS_ZERO && (addr == '0);
    // Bypass is disabled while reset is held: the write will be discarded,
    // so forwarding it would show a value that never reaches storage.
    assign hit     = write_en && !reset && (write_addr == addr);

    always_comb begin
        read_data = regs[addr];
        read_busy = busy[addr];
        if (is_zero) begin
            read_data = '0;
            read_busy = 1'b0;
        end else if (hit) begin
            // The producer is writing back right now, so the hazard is
            // resolved this cycle. A same-cycle busy set is deliberately
            // not reflected here; it shows up from the next cycle.
            read_data = write_data;
            read_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Multi-read-port register file with same-cycle write bypass and per-register busy scoreboard.
// Latency: reads 0 cycles (combinational); writes and busy sets land on the next rising edge.
// Backpressure: none; caller issues at most one write and one busy set per cycle.
//
// Ports:
//   clock, ctrl_reset                 clock and synchronous active-high reset
//   ctrl_writeEnable/writeReg         writeback: store data_writeReg, clear busy
//   data_writeReg                     writeback data
//   ctrl_busySet/busyReg              issue: mark a register as pending a write
//   ctrl_readReg                      NUM_READ packed read addresses
//   data_readReg, busy_readReg        NUM_READ packed read data and busy bits
//   busy_any                          OR of busy_readReg, decode stall hint
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  NUM_READ = DEF_NUM_READ,
    parameter int  ZERO_REG = ZERO_REG_ON,
    localparam int ADDR_W   = $clog2(DEPTH)
)(
    input  logic                         clock,
    input  logic                         ctrl_reset,
    input  logic                         ctrl_writeEnable,
    input  logic [ADDR_W-1:0]            ctrl_writeReg,
    input  logic [WIDTH-1:0]             data_writeReg,
    input  logic                         ctrl_busySet,
    input  logic [ADDR_W-1:0]            ctrl_busyReg,
    input  logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg,
    output logic [NUM_READ*WIDTH-1:0]    data_readReg,
    output logic [NUM_READ-1:0]          busy_readReg,
    output logic                         busy_any
);

    localparam bit HAS_ZERO = (ZERO_REG != ZERO_REG_OFF);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;

    logic write_ok;
    logic set_ok;

    // Address 0 is read-only-zero when HAS_ZERO; drop writes and sets to it.
    assign write_ok = ctrl_writeEnable && !(HAS_ZERO && (ctrl_writeReg == '0));
    assign set_ok   = ctrl_busySet     && !(HAS_ZERO && (ctrl_busyReg  == '0));

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (write_ok) begin
                regs[ctrl_writeReg] <= data_writeReg;
                busy[ctrl_writeReg] <= 1'b0;
            end
            // Placed after the clear so a new producer issuing on the same
            // register as a retiring one leaves the register busy.
            if (set_ok) begin
                busy[ctrl_busyReg] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        regfile_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .ADDR_W   (ADDR_W)
        ) u_port (
            .addr       (ctrl_readReg[p*ADDR_W +: ADDR_W]),
            .regs       (regs),
            .busy       (busy),
            .reset      (ctrl_reset),
            .write_en   (ctrl_writeEnable),
            .write_addr (ctrl_writeReg),
            .write_data (data_writeReg),
            .read_data  (data_readReg[p*WIDTH +: WIDTH]),
            .read_busy  (busy_readReg[p])
        );
    end

    assign busy_any = |busy_readReg;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: default 32x32/2-port instance with a zero register,
// plus an 8-bit/16-entry/4-port instance without one, checked against a small reference model.
module tb_regfile_bypass;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int vec  = 0;
    int miss = 0;

    // Instance A: WIDTH=32, DEPTH=32, NUM_READ=2, ZERO_REG=1
    logic        a_rst, a_we, a_bs, a_bany;
    logic [4:0]  a_wr, a_br;
    logic [31:0] a_wd;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rb;

    // Instance B: WIDTH=8, DEPTH=16, NUM_READ=4, ZERO_REG=0
    logic        b_rst, b_we, b_bs, b_bany;
    logic [3:0]  b_wr, b_br;
    logic [7:0]  b_wd;
    logic [15:0] b_ra;
    logic [31:0] b_rd;
    logic [3:0]  b_rb;

    regfile_bypass dut_a (
        .clock(clock), .ctrl_reset(a_rst), .ctrl_writeEnable(a_we), .ctrl_writeReg(a_wr),
        .data_writeReg(a_wd), .ctrl_busySet(a_bs), .ctrl_busyReg(a_br), .ctrl_readReg(a_ra),
        .data_readReg(a_rd), .busy_readReg(a_rb), .busy_any(a_bany)
    );

    regfile_bypass #(.WIDTH(8), .DEPTH(16), .NUM_READ(4), .ZERO_REG(0)) dut_b (
        .clock(clock), .ctrl_reset(b_rst), .ctrl_writeEnable(b_we), .ctrl_writeReg(b_wr),
        .data_writeReg(b_wd), .ctrl_busySet(b_bs), .ctrl_busyReg(b_br), .ctrl_readReg(b_ra),
        .data_readReg(b_rd), .busy_readReg(b_rb), .busy_any(b_bany)
    );

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        step();
        // Write attempted while reset is held; bypass must stay suppressed.
        a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hDEADBEEF;
        for (int a = 0; a < 32; a++) begin
            a_ra = {5'(31 - a), 5'(a)};
            #1;
            if (a_rd !== 64'h0) begin $display("FAIL reset_data_a addr=%0d got %h want 0", a, a_rd); miss++; end
            vec++;
            if (a_rb !== 2'b00 || a_bany !== 1'b0) begin $display("FAIL reset_busy_a addr=%0d got %b/%b want 00/0", a, a_rb, a_bany); miss++; end
            vec++;
        end
        for (int a = 0; a < 16; a++) begin
            b_ra = {4'(a), 4'(15 - a), 4'(a), 4'(a)};
            #1;
            if (b_rd !== 32'h0 || b_rb !== 4'h0) begin $display("FAIL reset_b addr=%0d got %h/%b want 0/0", a, b_rd, b_rb); miss++; end
            vec++;
        end
        step();
        a_rst = 1'b0; b_rst = 1'b0; a_we = 1'b0;
        a_ra = {5'd0, 5'd5};
        #1;
        if (a_rd[31:0] !== 32'h0) begin $display("FAIL reset_drops_write got %h want 00000000", a_rd[31:0]); miss++; end
        vec++;
    endtask

    task automatic test_bypass();
        a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h12345678;
        a_ra = {5'd6, 5'd7};
        #1;
        if (a_rd[31:0] !== 32'h12345678) begin $display("FAIL bypass_same_cycle got %h want 12345678", a_rd[31:0]); miss++; end
        vec++;
        if (a_rd[63:32] !== 32'h0) begin $display("FAIL bypass_other_port got %h want 00000000", a_rd[63:32]); miss++; end
        vec++;
        step();
        a_we = 1'b0; a_wd = 32'h0;
        #1;
        if (a_rd[31:0] !== 32'h12345678) begin $display("FAIL bypass_storage got %h want 12345678", a_rd[31:0]); miss++; end
        vec++;
    endtask

    task automatic test_zero_reg();
        a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hFFFFFFFF; a_bs = 1'b1; a_br = 5'd0;
        b_we = 1'b1; b_wr = 4'd0; b_wd = 8'hFF;       b_bs = 1'b1; b_br = 4'd0;
        a_ra = {5'd0, 5'd0}; b_ra = 16'h0000;
        #1;
        if (a_rd !== 64'h0 || a_rb !== 2'b00) begin $display("FAIL zero_same_cycle_a got %h/%b want 0/00", a_rd, a_rb); miss++; end
        vec++;
        if (b_rd !== 32'hFFFFFFFF || b_rb !== 4'h0) begin $display("FAIL zero_off_bypass_b got %h/%b want ffffffff/0000", b_rd, b_rb); miss++; end
        vec++;
        step();
        a_we = 1'b0; a_bs = 1'b0; b_we = 1'b0; b_bs = 1'b0;
        #1;
        if (a_rd !== 64'h0 || a_rb !== 2'b00 || a_bany !== 1'b0) begin $display("FAIL zero_reg_a got %h/%b/%b want 0/00/0", a_rd, a_rb, a_bany); miss++; end
        vec++;
        if (b_rd !== 32'hFFFFFFFF || b_rb !== 4'hF || b_bany !== 1'b1) begin $display("FAIL zero_off_b got %h/%b/%b want ffffffff/1111/1", b_rd, b_rb, b_bany); miss++; end
        vec++;
    endtask

    task automatic test_busy();
        a_bs = 1'b1; a_br = 5'd3;
        a_ra = {5'd3, 5'd3};
        #1;
        if (a_rb !== 2'b00) begin $display("FAIL busy_not_same_cycle got %b want 00", a_rb); miss++; end
        vec++;
        step();
        a_bs = 1'b0;
        #1;
        if (a_rb !== 2'b11 || a_bany !== 1'b1) begin $display("FAIL busy_set got %b/%b want 11/1", a_rb, a_bany); miss++; end
        vec++;
        a_we = 1'b1; a_wr = 5'd3; a_wd = 32'h55;
        #1;
        if (a_rb !== 2'b00 || a_bany !== 1'b0) begin $display("FAIL busy_clear_bypass got %b/%b want 00/0", a_rb, a_bany); miss++; end
        vec++;
        if (a_rd !== {32'h55, 32'h55}) begin $display("FAIL busy_clear_data got %h want 0000005500000055", a_rd); miss++; end
        vec++;
        step();
        a_we = 1'b0;
        #1;
        if (a_rb !== 2'b00 || a_rd[31:0] !== 32'h55) begin $display("FAIL busy_cleared_stored got %b/%h want 00/00000055", a_rb, a_rd[31:0]); miss++; end
        vec++;
    endtask

    task automatic test_set_and_clear();
        a_bs = 1'b1; a_br = 5'd9;
        step();
        a_we = 1'b1; a_wr = 5'd9; a_wd = 32'hA;
        a_ra = {5'd3, 5'd9};
        #1;
        if (a_rb[0] !== 1'b0 || a_rd[31:0] !== 32'hA) begin $display("FAIL set_clear_same_cycle got %b/%h want 0/0000000a", a_rb[0], a_rd[31:0]); miss++; end
        vec++;
        step();
        a_we = 1'b0; a_bs = 1'b0;
        #1;
        if (a_rb[0] !== 1'b1 || a_rd[31:0] !== 32'hA) begin $display("FAIL set_wins got %b/%h want 1/0000000a", a_rb[0], a_rd[31:0]); miss++; end
        vec++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_prev;
        for (int i = 0; i < 4; i++) begin
            a_we = 1'b1; a_wr = 5'(10 + i); a_wd = 32'hC0DE0000 + 32'(i);
            a_ra = {5'(9 + i), 5'(10 + i)};
            exp_prev = (i == 0) ? 32'hA : 32'hC0DE0000 + 32'(i - 1);
            #1;
            if (a_rd[31:0] !== 32'hC0DE0000 + 32'(i)) begin $display("FAIL b2b_bypass i=%0d got %h", i, a_rd[31:0]); miss++; end
            vec++;
            if (a_rd[63:32] !== exp_prev) begin $display("FAIL b2b_prev i=%0d got %h want %h", i, a_rd[63:32], exp_prev); miss++; end
            vec++;
            step();
        end
        a_we = 1'b0;
    endtask

    task automatic test_random_model();
        logic [7:0]  m_reg [16];
        logic [15:0] m_busy;
        logic [31:0] exp_d;
        logic [3:0]  exp_b;
        logic [3:0]  ra;
        for (int c = 0; c < 3000; c++) begin
            b_rst = (c == 0) || ($urandom_range(0, 63) == 0);
            b_we  = 1'($urandom_range(0, 1));
            b_wr  = 4'($urandom_range(0, 15));
            b_wd  = 8'($urandom);
            b_bs  = 1'($urandom_range(0, 1));
            b_br  = 4'($urandom_range(0, 15));
            b_ra  = 16'($urandom);
            // Bias one port toward the write address to exercise the bypass.
            if ($urandom_range(0, 2) == 0) b_ra[4 +: 4] = b_wr;
            #1;
            if (c > 0) begin
                for (int p = 0; p < 4; p++) begin
                    ra = b_ra[p*4 +: 4];
                    if (b_we && !b_rst && b_wr == ra) begin
                        exp_d[p*8 +: 8] = b_wd; exp_b[p] = 1'b0;
                    end else begin
                        exp_d[p*8 +: 8] = m_reg[ra]; exp_b[p] = m_busy[ra];
                    end
                end
                if (b_rd !== exp_d) begin $display("FAIL rand_data c=%0d got %h want %h", c, b_rd, exp_d); miss++; end
                vec++;
                if (b_rb !== exp_b || b_bany !== |exp_b) begin $display("FAIL rand_busy c=%0d got %b/%b want %b/%b", c, b_rb, b_bany, exp_b, |exp_b); miss++; end
                vec++;
            end
            step();
            if (b_rst) begin
                for (int r = 0; r < 16; r++) m_reg[r] = 8'h0;
                m_busy = 16'h0;
            end else begin
                if (b_we) begin m_reg[b_wr] = b_wd; m_busy[b_wr] = 1'b0; end
                if (b_bs) m_busy[b_br] = 1'b1;
            end
        end
        b_rst = 1'b0; b_we = 1'b0; b_bs = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_we = 1'b0; a_bs = 1'b0; a_wr = '0; a_br = '0; a_wd = '0; a_ra = '0;
        b_rst = 1'b1; b_we = 1'b0; b_bs = 1'b0; b_wr = '0; b_br = '0; b_wd = '0; b_ra = '0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_busy();
        test_set_and_clear();
        test_back_to_back();
        test_random_model();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
